// File: rtl/fifo_param.sv
// Parametrised circular-buffer FIFO with edge/level request qualification,
// occupancy flags, sticky error bits and a display scanner over valid entries.
module fifo_param #(
    parameter int WIDTH    = 4,
    parameter int AW       = 3,
    parameter int EDGE_IN  = 1,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             enq,
    input  logic [WIDTH-1:0] in,
    input  logic             deq,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf,
    output logic [AW-1:0]    an,
    output logic [WIDTH-1:0] seg,
    output logic             scan_en
);
    localparam int          DEPTH    = 1 << AW;
    localparam int          DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C     = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C     = (AW+1)'(AE_LEVEL);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic        EDGE     = (EDGE_IN != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic             enq_q, deq_q, eq, dq, acc_enq, acc_deq;
    logic [DW-1:0]    div;
    logic [AW-1:0]    nxt, cand;

    // History is always kept so level mode simply masks it out.
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_q <= 1'b0;
            deq_q <= 1'b0;
        end else begin
            enq_q <= enq;
            deq_q <= deq;
        end
    end

    assign eq      = enq & ~(EDGE & enq_q);
    assign dq      = deq & ~(EDGE & deq_q);
    assign acc_deq = dq & ~empty;
    assign acc_enq = eq & (~full | acc_deq);

    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            out   <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (acc_enq) tail <= tail + 1'b1;
            if (acc_deq) begin
                out  <= mem[head];
                head <= head + 1'b1;
            end
            if (acc_enq & ~acc_deq)      count <= count + 1'b1;
            else if (acc_deq & ~acc_enq) count <= count - 1'b1;
            if (eq & full & ~acc_deq) ovf <= 1'b1;
            if (dq & empty)           udf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && acc_enq) mem[tail] <= in;
    end

    // Nearest valid slot after an, circularly; descending loop lets the smallest step win.
    always_comb begin
        nxt  = an;
        cand = an;
        for (int k = DEPTH; k >= 1; k--) begin
            cand = an + AW'(k);
            if ({1'b0, AW'(cand - head)} < count) nxt = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            an      <= '0;
            scan_en <= 1'b0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (div == DIV_LAST && !empty) an <= nxt;
            scan_en <= !empty;
        end
    end

    assign seg = scan_en ? mem[an] : '0;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench: level-mode instance driven from a vector table, edge-mode
// instance driven by hand-written pulse sequences.
module tb_fifo_param;
    logic clk = 1'b0;
    logic rst, clr, enq_e, deq_e, enq_l, deq_l;
    logic [3:0] din;

    logic [3:0] e_out, e_seg, l_out, l_seg;
    logic [3:0] e_cnt, l_cnt;
    logic [2:0] e_an, l_an;
    logic e_full, e_empty, e_af, e_ae, e_ovf, e_udf, e_sen;
    logic l_full, l_empty, l_af, l_ae, l_ovf, l_udf, l_sen;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(4), .AW(3), .EDGE_IN(1), .AF_LEVEL(6), .AE_LEVEL(2), .SCAN_DIV(4)) u_edge (
        .clk(clk), .rst(rst), .clr(clr), .enq(enq_e), .in(din), .deq(deq_e),
        .out(e_out), .full(e_full), .empty(e_empty), .almost_full(e_af),
        .almost_empty(e_ae), .count(e_cnt), .ovf(e_ovf), .udf(e_udf),
        .an(e_an), .seg(e_seg), .scan_en(e_sen));

    fifo_param #(.WIDTH(4), .AW(3), .EDGE_IN(0), .AF_LEVEL(6), .AE_LEVEL(2), .SCAN_DIV(4)) u_lvl (
        .clk(clk), .rst(rst), .clr(clr), .enq(enq_l), .in(din), .deq(deq_l),
        .out(l_out), .full(l_full), .empty(l_empty), .almost_full(l_af),
        .almost_empty(l_ae), .count(l_cnt), .ovf(l_ovf), .udf(l_udf),
        .an(l_an), .seg(l_seg), .scan_en(l_sen));

    typedef struct {
        logic       clr, enq, deq;
        logic [3:0] din;
        int         cnt;
        logic [3:0] out;
        logic       ovf, udf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic e, input logic d, input logic [3:0] v);
        enq_e = e;
        deq_e = d;
        din   = v;
        step();
        enq_e = 1'b0;
        deq_e = 1'b0;
        step();
    endtask

    task automatic chk_edge_flags(input string name, input int c);
        chk({name, ".count"}, 32'(e_cnt), 32'(c));
        chk({name, ".full"}, 32'(e_full), 32'(c == 8));
        chk({name, ".empty"}, 32'(e_empty), 32'(c == 0));
        chk({name, ".af"}, 32'(e_af), 32'(c >= 6));
        chk({name, ".ae"}, 32'(e_ae), 32'(c <= 2));
    endtask

    logic [3:0] exp_mem [8];
    logic [7:0] visited;

    initial begin
        rst = 1'b1; clr = 1'b0; enq_e = 1'b0; deq_e = 1'b0;
        enq_l = 1'b0; deq_l = 1'b0; din = 4'h0;
        step(); step();
        rst = 1'b0;

        // reset state, both instances
        chk("rst.e_out", 32'(e_out), 0);
        chk("rst.e_ovf", 32'(e_ovf), 0);
        chk("rst.e_udf", 32'(e_udf), 0);
        chk("rst.e_an", 32'(e_an), 0);
        chk("rst.e_seg", 32'(e_seg), 0);
        chk("rst.e_scan_en", 32'(e_sen), 0);
        chk_edge_flags("rst.e", 0);
        chk("rst.l_count", 32'(l_cnt), 0);
        chk("rst.l_out", 32'(l_out), 0);

        // ---------------- level-mode table ----------------
        for (int i = 1; i <= 8; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, 4'(i), i, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'h9, 8, 4'h1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'hA, 8, 4'h2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'hB, 8, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 8, 4'h3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'h0, 0, 4'h3, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'h7, 1, 4'h3, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'h0, 0, 4'h7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h6, 0, 4'h7, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            clr = tbl[i].clr; enq_l = tbl[i].enq; deq_l = tbl[i].deq; din = tbl[i].din;
            step();
            chk($sformatf("lvl[%0d].count", i), 32'(l_cnt), 32'(tbl[i].cnt));
            chk($sformatf("lvl[%0d].out", i), 32'(l_out), 32'(tbl[i].out));
            chk($sformatf("lvl[%0d].full", i), 32'(l_full), 32'(tbl[i].cnt == 8));
            chk($sformatf("lvl[%0d].empty", i), 32'(l_empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("lvl[%0d].af", i), 32'(l_af), 32'(tbl[i].cnt >= 6));
            chk($sformatf("lvl[%0d].ae", i), 32'(l_ae), 32'(tbl[i].cnt <= 2));
            chk($sformatf("lvl[%0d].ovf", i), 32'(l_ovf), 32'(tbl[i].ovf));
            chk($sformatf("lvl[%0d].udf", i), 32'(l_udf), 32'(tbl[i].udf));
        end
        clr = 1'b0; enq_l = 1'b0; deq_l = 1'b0;

        // ---------------- edge mode: held enq gives one request ----------------
        enq_e = 1'b1; din = 4'hA;
        step();
        chk_edge_flags("hold1", 1);
        repeat (4) step();
        chk_edge_flags("hold5", 1);
        enq_e = 1'b0;
        step();
        pulse(1'b1, 1'b0, 4'h3);
        chk_edge_flags("second", 2);
        clr = 1'b1; step(); clr = 1'b0;
        chk_edge_flags("clr", 0);

        // fill, overflow, drain with head wrap
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b1, 1'b0, 4'(i));
            chk_edge_flags($sformatf("fill%0d", i), i);
        end
        pulse(1'b1, 1'b0, 4'h9);
        chk_edge_flags("ovf", 8);
        chk("ovf.flag", 32'(e_ovf), 1);
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b0, 1'b1, 4'h0);
            chk($sformatf("drain%0d.out", i), 32'(e_out), 32'(i));
            chk($sformatf("drain%0d.count", i), 32'(e_cnt), 32'(8 - i));
        end
        chk("drain.empty", 32'(e_empty), 1);
        chk("drain.ovf_sticky", 32'(e_ovf), 1);
        pulse(1'b0, 1'b1, 4'h0);
        chk("udf.flag", 32'(e_udf), 1);
        chk("udf.out_hold", 32'(e_out), 8);
        pulse(1'b1, 1'b0, 4'h5);
        pulse(1'b0, 1'b1, 4'h0);
        chk("wrap0.out", 32'(e_out), 5);
        chk("wrap0.udf_sticky", 32'(e_udf), 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr2.udf", 32'(e_udf), 0);
        chk("clr2.ovf", 32'(e_ovf), 0);
        chk("clr2.count", 32'(e_cnt), 0);
        chk("clr2.out_hold", 32'(e_out), 5);

        // ---------------- wrap-around and scanner ----------------
        exp_mem = '{4'hB, 4'hC, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA};
        for (int i = 1; i <= 6; i++) pulse(1'b1, 1'b0, 4'(i));
        for (int i = 1; i <= 5; i++) pulse(1'b0, 1'b1, 4'h0);
        chk("wrap.deq5.out", 32'(e_out), 5);
        for (int i = 9; i <= 12; i++) pulse(1'b1, 1'b0, 4'(i));
        chk_edge_flags("wrap", 5);
        repeat (5) step();
        visited = '0;
        for (int c = 0; c < 80; c++) begin
            visited[e_an] = 1'b1;
            if (c % 8 == 0) begin
                chk("scan.en", 32'(e_sen), 1);
                chk("scan.seg", 32'(e_seg), 32'(exp_mem[e_an]));
            end
            step();
        end
        chk("scan.visited", 32'(visited), 32'h0E3);
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 1'b1, 4'h0);
            chk($sformatf("wdrain%0d.out", i), 32'(e_out), 32'(exp_mem[(5 + i) % 8]));
        end
        chk("wdrain.empty", 32'(e_empty), 1);
        chk("wdrain.scan_en", 32'(e_sen), 0);

        // ---------------- reset mid-stream ----------------
        for (int i = 1; i <= 4; i++) pulse(1'b1, 1'b0, 4'(i));
        pulse(1'b0, 1'b1, 4'h0);
        chk("pre_rst.count", 32'(e_cnt), 3);
        chk("pre_rst.out", 32'(e_out), 1);
        enq_e = 1'b1; din = 4'h7; rst = 1'b1;
        step();
        enq_e = 1'b0; rst = 1'b0;
        chk_edge_flags("mid_rst", 0);
        chk("mid_rst.out", 32'(e_out), 0);
        chk("mid_rst.scan_en", 32'(e_sen), 0);
        step();
        chk("post_rst.count", 32'(e_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
